// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin write arbiter and sequencer for a bank of
// 2**AW flip-flop registers, with a combinational read port.
// A grant takes two cycles: arbitrate/capture in IDLE, commit in ACTIVE.
// Optional macro DFF_ARB_FIXED_PRIO_EN: lowest-index request always wins
// and the round-robin pointer is not built.
module dff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    addr,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    input  logic [AW-1:0]         rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             r_state;
    logic [NREQ-1:0]    r_gnt;
    logic               r_busy;
    logic [AW-1:0]      r_hold_addr;
    logic [WIDTH-1:0]   r_hold_data;
    logic [WIDTH-1:0]   r_bank [DEPTH];

    logic [PW-1:0]      w_base;
    logic [PW-1:0]      w_win;
    logic               w_found;

`ifdef DFF_ARB_FIXED_PRIO_EN
    // Search always starts at requester 0, so the lowest set bit wins.
    assign w_base = '0;
`else
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_win;
    assign w_base = r_ptr;
`endif

    // Requester index reached by stepping 'off' places from 'base', wrapping at NREQ.
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end else begin
            sum = sum;
        end
        return PW'(sum);
    endfunction

    // Winner search: first set req bit starting at the base index.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int off = 0; off < NREQ; off++) begin
            if (!w_found && req[rr_index(w_base, off)]) begin
                w_found = 1'b1;
                w_win   = rr_index(w_base, off);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Two-state sequencer: capture winner in IDLE, commit to the bank in ACTIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_hold_addr <= '0;
            r_hold_data <= '0;
`ifndef DFF_ARB_FIXED_PRIO_EN
            r_ptr       <= '0;
            r_win       <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_hold_addr <= addr[w_win*AW +: AW];
                        r_hold_data <= wdata[w_win*WIDTH +: WIDTH];
                        r_gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                        r_busy      <= 1'b1;
`ifndef DFF_ARB_FIXED_PRIO_EN
                        r_win       <= w_win;
`endif
                        r_state     <= ACTIVE;
                    end else begin
                        r_gnt       <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                ACTIVE: begin
                    // req is deliberately ignored here; the held values are committed.
                    r_bank[r_hold_addr] <= r_hold_data;
                    r_gnt               <= '0;
                    r_busy              <= 1'b0;
                    r_state             <= IDLE;
`ifndef DFF_ARB_FIXED_PRIO_EN
                    if (r_win == PW'(NREQ - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_win + {{(PW-1){1'b0}}, 1'b1};
                    end
`endif
                end
                default: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    // No write bypass: the read shows the stored value until the write edge.
    assign rd_data = r_bank[rd_addr];

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed self-checking bench for dff_bank_arbiter (NREQ=4, WIDTH=8, AW=2).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge, or at explicit points for asynchronous reset checks.
module tb_dff_bank_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        busy;
    logic [1:0]  rd_addr;
    logic [7:0]  rd_data;

    int n_cmp;
    int n_fail;

    dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .AW(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .addr    (addr),
        .wdata   (wdata),
        .gnt     (gnt),
        .busy    (busy),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_rr [5];
    logic [7:0] exp_bank [4];

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = 4'b0000;
        addr    = 8'h00;
        wdata   = 32'h0000_0000;
        rd_addr = 2'd0;

        // Reset state, visible before any clock edge
        #1;
        check("reset_gnt", {28'h0, gnt}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            check("reset_rd_data", {24'h0, rd_data}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single write: requester 2 writes A5 to address 3
        @(negedge clk);
        req     = 4'b0100;
        addr    = 8'b0011_0000;
        wdata   = 32'h00A5_0000;
        rd_addr = 2'd3;
        step_sample();
        check("single_gnt", {28'h0, gnt}, 32'h4);
        check("single_busy", {31'h0, busy}, 32'h1);
        check("single_no_bypass", {24'h0, rd_data}, 32'h0);
        @(negedge clk);
        req = 4'b0000;
        step_sample();
        check("single_gnt_clear", {28'h0, gnt}, 32'h0);
        check("single_busy_clear", {31'h0, busy}, 32'h0);
        check("single_rd_data", {24'h0, rd_data}, 32'hA5);

        // Round-robin from reset with all requesters active
        do_reset();
`ifdef DFF_ARB_FIXED_PRIO_EN
        exp_rr   = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        exp_bank = '{8'h10, 8'h00, 8'h00, 8'h00};
`else
        exp_rr   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_bank = '{8'h10, 8'h11, 8'h12, 8'h13};
`endif
        @(negedge clk);
        req   = 4'b1111;
        addr  = 8'b11_10_01_00;
        wdata = 32'h1312_1110;
        for (int g = 0; g < 5; g++) begin
            step_sample();
            check("rr_gnt", {28'h0, gnt}, {28'h0, exp_rr[g]});
            step_sample();
            check("rr_gap", {28'h0, gnt}, 32'h0);
        end
        @(negedge clk);
        req = 4'b0000;
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            check("rr_bank", {24'h0, rd_data}, {24'h0, exp_bank[a]});
        end

        // Pointer wrap: grant 3, then 0, then 3 again
        do_reset();
        @(negedge clk);
        req   = 4'b1000;
        addr  = 8'h00;
        wdata = 32'h0;
        step_sample();
        check("wrap_first", {28'h0, gnt}, 32'h8);
        @(negedge clk);
        req = 4'b1001;
        step_sample();
        check("wrap_gap1", {28'h0, gnt}, 32'h0);
        step_sample();
        check("wrap_to_0", {28'h0, gnt}, 32'h1);
        step_sample();
        check("wrap_gap2", {28'h0, gnt}, 32'h0);
        step_sample();
`ifdef DFF_ARB_FIXED_PRIO_EN
        check("wrap_third", {28'h0, gnt}, 32'h1);
`else
        check("wrap_third", {28'h0, gnt}, 32'h8);
`endif
        step_sample();
        check("wrap_gap3", {28'h0, gnt}, 32'h0);
        @(negedge clk);
        req = 4'b0000;

        // Data capture: wdata change during the grant cycle is not written
        @(negedge clk);
        req     = 4'b0001;
        addr    = 8'b0000_0010;
        wdata   = 32'h0000_0011;
        step_sample();
        check("capture_gnt", {28'h0, gnt}, 32'h1);
        wdata = 32'h0000_0022;
        req   = 4'b0000;
        step_sample();
        rd_addr = 2'd2;
        #1;
        check("capture_bank", {24'h0, rd_data}, 32'h11);

        // Abort: reset during ACTIVE drops gnt/busy at once and clears the bank
        @(negedge clk);
        req   = 4'b0010;
        addr  = 8'b0000_1000;
        wdata = 32'h0000_7700;
        step_sample();
        check("abort_gnt", {28'h0, gnt}, 32'h2);
        check("abort_busy", {31'h0, busy}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_gnt_drop", {28'h0, gnt}, 32'h0);
        check("abort_busy_drop", {31'h0, busy}, 32'h0);
        check("abort_bank_clear", {24'h0, rd_data}, 32'h0);
        req = 4'b0000;
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step_sample();
            check("abort_no_gnt", {28'h0, gnt}, 32'h0);
        end
        check("abort_bank_after", {24'h0, rd_data}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
